// File: rtl/seq_detect_pkg.sv
// Shared types and reset constants for the programmable symbol sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int SYM_W_DEF   = 3;
  localparam int DEFAULT_LEN = 8;

  // Slot 0 sits in the least significant position: 001,101,110,000,110,110,011,101.
  localparam logic [DEFAULT_LEN-1:0][SYM_W_DEF-1:0] DEFAULT_PATTERN = {
    3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001
  };

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational compare of the stored symbol history plus the incoming symbol
// against the first len slots of the programmed pattern.
module seq_window_cmp #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = IDX_W + 1
) (
  input  logic [MAX_LEN-2:0][SYM_W-1:0] hist,
  input  logic [SYM_W-1:0]              sym,
  input  logic [MAX_LEN-1:0][SYM_W-1:0] pattern,
  input  logic [LEN_W-1:0]              len,
  input  logic [LEN_W-1:0]              fill,
  output logic                          match
);

  logic             hit;
  logic [IDX_W-1:0] pidx;

  // hist[0] is the newest stored symbol, so it lines up with pattern slot len-2.
  always_comb begin
    hit  = (pattern[IDX_W'(len - LEN_W'(1))] == sym);
    pidx = '0;
    for (int k = 0; k < MAX_LEN - 1; k++) begin
      pidx = IDX_W'(len - LEN_W'(2) - LEN_W'(k));
      if ((LEN_W'(k) < len - LEN_W'(1)) && (pattern[pidx] != hist[k]))
        hit = 1'b0;
    end
  end

  assign match = hit && (({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len});

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable sequence detector controller: pattern/length config, arm/disarm
// FSM, history window and saturating match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = $clog2(MAX_LEN),
  localparam int LEN_W  = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_len_we,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             cfg_err,
  input  logic             arm,
  input  logic             disarm,
  input  logic             oneshot,
  input  logic             data_valid,
  input  logic [SYM_W-1:0] data,
  output logic             sequence_found,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  state_t                        state;
  logic                          oneshot_q;
  logic [MAX_LEN-1:0][SYM_W-1:0] pat;
  logic [LEN_W-1:0]              len;
  logic [MAX_LEN-2:0][SYM_W-1:0] hist;
  logic [LEN_W-1:0]              fill;
  logic                          match;

  seq_window_cmp #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .hist    (hist),
    .sym     (data),
    .pattern (pat),
    .len     (len),
    .fill    (fill),
    .match   (match)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      armed          <= 1'b0;
      sequence_found <= 1'b0;
      cfg_err        <= 1'b0;
      match_count    <= '0;
      oneshot_q      <= 1'b0;
      hist           <= '0;
      fill           <= '0;
      len            <= LEN_W'(DEFAULT_LEN);
      for (int i = 0; i < MAX_LEN; i++)
        pat[i] <= SYM_W'(DEFAULT_PATTERN[i % DEFAULT_LEN]);
    end else begin
      sequence_found <= 1'b0;
      cfg_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we)
            pat[cfg_idx] <= cfg_sym;
          if (cfg_len_we) begin
            if (cfg_len == '0 || cfg_len > LEN_W'(MAX_LEN))
              cfg_err <= 1'b1;
            else
              len <= cfg_len;
          end
          if (arm && !disarm) begin
            state       <= ARMED;
            armed       <= 1'b1;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            oneshot_q   <= oneshot;
          end
        end
        ARMED: begin
          if (cfg_we || cfg_len_we)
            cfg_err <= 1'b1;
          if (data_valid) begin
            hist[0] <= data;
            for (int i = 1; i < MAX_LEN - 1; i++)
              hist[i] <= hist[i-1];
            if (fill != LEN_W'(MAX_LEN))
              fill <= fill + LEN_W'(1);
            if (match) begin
              sequence_found <= 1'b1;
              if (match_count != '1)
                match_count <= match_count + CNT_W'(1);
            end
          end
          // A completing symbol alongside disarm is still reported above.
          if (disarm) begin
            state <= IDLE;
            armed <= 1'b0;
          end else if (data_valid && match && oneshot_q) begin
            state <= HOLD;
            armed <= 1'b0;
          end
        end
        HOLD: begin
          if (cfg_we || cfg_len_we)
            cfg_err <= 1'b1;
          if (disarm)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Programmable controller for the 3-bit symbol sequence detector datapath.
- Holds a configurable target pattern of 1..MAX_LEN symbols and sequences arm/disarm of matching.
- Feeds the symbol stream through a sliding history window and raises a one-cycle `sequence_found` per match; overlapping matches are counted.
- Sits between the symbol source and the status/IRQ logic; replaces the fixed-pattern detector.

Parameters:
- SYM_W, 3, symbol width in bits
- MAX_LEN, 8, maximum pattern length in symbols (power of two, at least 2)
- CNT_W, 8, width of the match counter

Ports:
- clk  in  1  system clock, all state updated on rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write pattern symbol cfg_sym at slot cfg_idx
- cfg_idx  in  $clog2(MAX_LEN)  pattern slot; slot 0 is the first symbol of the sequence
- cfg_sym  in  SYM_W  symbol value to write
- cfg_len_we  in  1  write pattern length cfg_len
- cfg_len  in  $clog2(MAX_LEN)+1  pattern length, legal range 1..MAX_LEN
- cfg_err  out  1  one-cycle pulse when a config write is rejected
- arm  in  1  start matching (pulse)
- disarm  in  1  stop matching (pulse)
- oneshot  in  1  sampled on arm; 1 = stop after the first match
- data_valid  in  1  data carries a symbol this cycle
- data  in  SYM_W  input symbol
- sequence_found  out  1  registered one-cycle match pulse
- armed  out  1  high in ARMED state
- match_count  out  CNT_W  saturating number of matches since the last arm

Behaviour:
- Reset values:
  - state IDLE; armed=0, sequence_found=0, cfg_err=0, match_count=0.
  - History and fill count cleared.
  - Pattern = 001,101,110,000,110,110,011,101; length = 8.
- FSM states:
  - IDLE: config writes accepted; data ignored.
  - ARMED: matching.
  - HOLD: oneshot hit; data ignored; waits for disarm.
- Transitions:
  - IDLE -(arm & !disarm)-> ARMED. On this transition: clear history, clear fill count, clear match_count, latch oneshot.
  - ARMED -disarm-> IDLE.
  - ARMED -(match & oneshot_latched)-> HOLD.
  - HOLD -disarm-> IDLE.
  - arm in ARMED or HOLD is ignored.
  - arm and disarm in the same cycle: disarm wins; IDLE stays IDLE.
- Matching, in ARMED with data_valid=1 at a rising edge:
  - candidate = last (len-1) stored symbols followed by data.
  - match = (fill+1 >= len) and candidate equals pattern[0..len-1] in order.
  - History shifts in data; fill saturates at MAX_LEN.
  - data_valid=0 leaves history unchanged (gaps are transparent).
- Latency: sequence_found is registered at the edge that samples the completing symbol. It is high for exactly the following cycle.
- Overlap: after a match, history is not cleared, so overlapping matches are detected. Example: pattern 101,101 with input 101,101,101 gives 2 matches.
- match_count increments on each match and saturates at 2^CNT_W-1.
- Config writes:
  - Accepted only in IDLE; take effect the next cycle.
  - cfg_we or cfg_len_we in ARMED or HOLD: no write, cfg_err pulses.
  - cfg_len of 0 or greater than MAX_LEN: rejected, cfg_err pulses.
  - cfg_we and cfg_len_we in the same cycle: both applied.
- Disarm in the same cycle as a completing symbol: the match is still reported and counted; state goes to IDLE.
- Reset asserted mid-operation: immediate return to reset values. This includes restoring the default pattern and length.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum (IDLE, ARMED, HOLD)
  - SYM_W default
  - the DEFAULT_PATTERN constant array
  - DEFAULT_LEN = 8
- One sub-module: seq_window_cmp. It is purely combinational: history window, incoming symbol, pattern, len and fill in; match out.
- The FSM, config registers and counter stay in seq_detect_ctrl.

Test Plan:
- Reset, arm (oneshot=0), then feed 001,101,110,000,110,110,011,101 one per cycle → sequence_found=1 only in the cycle after the 8th symbol; match_count=1.
- Program len=2, pattern 101,101; arm; feed 101,101,101 → sequence_found pulses after symbols 2 and 3; match_count=2.
- Same pattern with oneshot=1; feed 101×4 → one pulse, state HOLD; armed=0; match_count stays 1 until disarm.
- While ARMED: cfg_we slot 0 = 111 → cfg_err pulses and the pattern is unchanged. In IDLE: cfg_len=0 → cfg_err pulses; cfg_len=9 → cfg_err pulses.
- Default pattern fed with data_valid=0 gaps between symbols → single match, same as gap-free.
- Assert reset_n=0 after 5 of 8 default symbols, release, arm, feed the last 3 symbols → no match. Assert arm and disarm in the same cycle → armed stays 0.
